// File: rtl/uart_pkg.sv
// Shared state encoding and default frame constants for the UART receive path.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// RX line synchroniser plus rising-edge detect that turns the oversample square wave
// into a one-clock enable.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_serial_i,
  input  logic tick_i,
  output logic rx_sync_o,
  output logic tick_en_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   tick_q;

  // Flops reset to 1 so an idle-high line never looks like a start edge out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      tick_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial_i};
      tick_q <= tick_i;
    end
  end

  assign rx_sync_o = sync_q[SYNC_STAGES-1];
  assign tick_en_o = tick_i & ~tick_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver: start/data/parity/stop FSM feeding a one-word
// valid/ready holding register with sticky overrun.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_Rx_ClkTick,
  input  logic                 i_Rx_Serial,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Valid,
  input  logic                 i_Rx_Ready,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  logic rx_sync, tick_en;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_serial_i(i_Rx_Serial),
    .tick_i     (i_Rx_ClkTick),
    .rx_sync_o  (rx_sync),
    .tick_en_o  (tick_en)
  );

  rx_state_e              state_q, state_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_err_q, par_err_d;
  logic                   armed_q, armed_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   perr_q, perr_d;
  logic                   ovr_q, ovr_d;
  logic                   complete, stop_bad, load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      armed_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      armed_q    <= armed_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
    end
  end

  // A break (all-zero data, stop low) disarms start detection until the line is seen high again.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    armed_d    = armed_q;
    complete   = 1'b0;
    stop_bad   = 1'b0;
    if (tick_en) begin
      case (state_q)
        IDLE: begin
          tick_cnt_d = '0;
          if (rx_sync)      armed_d = 1'b1;
          else if (armed_q) state_d = START;
        end
        START: begin
          if (tick_cnt_q == TICK_HALF) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            par_err_d  = 1'b0;
            state_d    = rx_sync ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_sync, shift_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + BIT_ONE;
            if (bit_cnt_q == BIT_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end
        PARITY: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            par_err_d  = ((^shift_q) ^ rx_sync) != PAR_ODD;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end
        STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            complete   = 1'b1;
            stop_bad   = ~rx_sync;
            state_d    = IDLE;
            if (!rx_sync && (shift_q == '0)) armed_d = 1'b0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A same-cycle accept frees the slot, so a completing frame can replace the word being taken.
  always_comb begin
    load    = complete & (~valid_q | i_Rx_Ready);
    valid_d = valid_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;
    if (valid_q && i_Rx_Ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      ferr_d  = stop_bad;
      perr_d  = par_err_q;
    end else if (complete) begin
      ovr_d = 1'b1;
    end
  end

  assign o_Rx_Data    = data_q;
  assign o_Rx_Valid   = valid_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Parity_Err = perr_q;
  assign o_Overrun    = ovr_q;
  assign o_Busy       = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench: instance A uses defaults, instance B has odd parity enabled.
module tb_uart_rx_oversampled;

  localparam int BIT = 64;

  logic clk = 1'b0, reset_n = 1'b0, tick = 1'b0;
  logic rxA = 1'b1, rxB = 1'b1, readyA = 1'b0, readyB = 1'b1;
  logic [7:0] dataA, dataB;
  logic validA, validB, ferrA, ferrB, perrA, perrB, ovrA, ovrB, busyA, busyB;
  int nChecks = 0, nFail = 0;

  typedef struct packed { logic [7:0] data; logic ferr; logic perr; } word_t;
  typedef struct { logic [7:0] data; logic stopBit; logic [7:0] expData; logic expFerr; } vec_t;
  word_t gotA[$], gotB[$];

  uart_rx_oversampled dutA (
    .clk(clk), .reset_n(reset_n), .i_Rx_ClkTick(tick), .i_Rx_Serial(rxA),
    .o_Rx_Data(dataA), .o_Rx_Valid(validA), .i_Rx_Ready(readyA),
    .o_Frame_Err(ferrA), .o_Parity_Err(perrA), .o_Overrun(ovrA), .o_Busy(busyA));

  uart_rx_oversampled #(.PARITY_EN(1), .PARITY_ODD(1)) dutB (
    .clk(clk), .reset_n(reset_n), .i_Rx_ClkTick(tick), .i_Rx_Serial(rxB),
    .o_Rx_Data(dataB), .o_Rx_Valid(validB), .i_Rx_Ready(readyB),
    .o_Frame_Err(ferrB), .o_Parity_Err(perrB), .o_Overrun(ovrB), .o_Busy(busyB));

  always #5 clk = ~clk;

  // Tick toggles on falling clk edges: 4 clk per tick, 64 clk per bit.
  initial begin
    forever #20 tick = ~tick;
  end

  // Record every accepted handshake so frames can be checked after they are sent.
  always @(negedge clk) begin
    if (validA && readyA) gotA.push_back({dataA, ferrA, perrA});
    if (validB && readyB) gotB.push_back({dataB, ferrB, perrB});
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setLine(input int which, input logic b);
    if (which == 0) rxA = b;
    else            rxB = b;
  endtask

  task automatic applyStimulus(input int which, input logic [7:0] d, input logic hasPar,
                               input logic pbit, input logic stopBit);
    setLine(which, 1'b0);
    waitClk(BIT);
    for (int i = 0; i < 8; i++) begin
      setLine(which, d[i]);
      waitClk(BIT);
    end
    if (hasPar) begin
      setLine(which, pbit);
      waitClk(BIT);
    end
    setLine(which, stopBit);
    waitClk(BIT);
    setLine(which, 1'b1);
  endtask

  // Reference parity rule: the frame is good when the count of ones over data+parity
  // has the parity the link is configured for.
  function automatic logic modelParityErr(input logic [7:0] d, input logic pbit, input logic odd);
    int ones;
    ones = $countones(d) + int'(pbit);
    return ((ones % 2) == 1) != odd;
  endfunction

  task automatic checkWord(input int which, input string name, input logic [7:0] d,
                           input logic f, input logic p);
    word_t w;
    int n;
    n = (which == 0) ? gotA.size() : gotB.size();
    checkOutput({name, " word count"}, n, 1);
    if (n > 0) begin
      if (which == 0) w = gotA.pop_front();
      else            w = gotB.pop_front();
      checkOutput({name, " data"}, w.data, d);
      checkOutput({name, " frame_err"}, w.ferr, f);
      checkOutput({name, " parity_err"}, w.perr, p);
    end
    gotA.delete();
    gotB.delete();
  endtask

  initial begin
    vec_t vecs[6];
    logic ok;
    logic busySeen;
    logic [7:0] rd;
    logic rs, rp;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h5A, 1'b1, 8'h5A, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h81, 1'b1, 8'h81, 1'b0};

    // Reset state
    waitClk(4);
    checkOutput("reset valid", validA, 0);
    checkOutput("reset data", dataA, 0);
    checkOutput("reset frame_err", ferrA, 0);
    checkOutput("reset overrun", ovrA, 0);
    checkOutput("reset busy", busyA, 0);
    checkOutput("reset B parity_err", perrB, 0);
    reset_n = 1'b1;
    waitClk(BIT);

    // 0xA5 with latency check: Valid rises on the same edge Busy falls
    readyA = 1'b1;
    fork
      applyStimulus(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if (busyA) begin ok = 1'b1; break; end
        end
        checkOutput("A5 busy rise", ok, 1);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if (!busyA) begin ok = 1'b1; break; end
        end
        checkOutput("A5 busy fall", ok, 1);
        checkOutput("A5 valid latency", validA, 1);
        checkOutput("A5 data", dataA, 8'hA5);
        checkOutput("A5 frame_err", ferrA, 0);
        checkOutput("A5 parity_err", perrA, 0);
        checkOutput("A5 overrun", ovrA, 0);
        @(negedge clk);
        checkOutput("A5 single pulse", validA, 0);
      end
    join
    waitClk(2 * BIT);
    checkWord(0, "A5 handshake", 8'hA5, 1'b0, 1'b0);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, vecs[i].data, 1'b0, 1'b0, vecs[i].stopBit);
      waitClk(2 * BIT);
      checkWord(0, $sformatf("vec%0d", i), vecs[i].expData, vecs[i].expFerr, 1'b0);
    end

    // False start: 3 ticks low must never confirm
    busySeen = 1'b0;
    fork
      begin
        setLine(0, 1'b0);
        waitClk(12);
        setLine(0, 1'b1);
      end
      for (int i = 0; i < 160; i++) begin
        @(negedge clk);
        if (busyA) busySeen = 1'b1;
      end
    join
    waitClk(4);
    checkOutput("false start busy", busySeen, 0);
    checkOutput("false start no word", gotA.size(), 0);
    applyStimulus(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    waitClk(2 * BIT);
    checkWord(0, "after false start", 8'h5A, 1'b0, 1'b0);

    // Frame error then a long break: exactly one break word, no retrigger while low
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    waitClk(2 * BIT);
    checkWord(0, "stop low", 8'h3C, 1'b1, 1'b0);
    setLine(0, 1'b0);
    waitClk(24 * BIT);
    @(negedge clk);
    checkOutput("break busy", busyA, 0);
    #1;
    checkWord(0, "break", 8'h00, 1'b1, 1'b0);
    waitClk(1);
    setLine(0, 1'b1);
    waitClk(BIT);
    applyStimulus(0, 8'h81, 1'b0, 1'b0, 1'b1);
    waitClk(2 * BIT);
    checkWord(0, "after break", 8'h81, 1'b0, 1'b0);

    // Overrun: second frame dropped while the first is held
    readyA = 1'b0;
    applyStimulus(0, 8'h11, 1'b0, 1'b0, 1'b1);
    waitClk(BIT);
    applyStimulus(0, 8'h22, 1'b0, 1'b0, 1'b1);
    waitClk(2 * BIT);
    @(negedge clk);
    checkOutput("overrun valid held", validA, 1);
    checkOutput("overrun data kept", dataA, 8'h11);
    checkOutput("overrun flag", ovrA, 1);
    waitClk(1);
    readyA = 1'b1;
    waitClk(1);
    readyA = 1'b0;
    @(negedge clk);
    checkOutput("overrun accept valid", validA, 0);
    checkOutput("overrun cleared", ovrA, 0);
    #1;
    checkWord(0, "overrun accepted", 8'h11, 1'b0, 1'b0);
    waitClk(1);

    // Odd parity on instance B
    applyStimulus(1, 8'h07, 1'b1, 1'b0, 1'b1);
    waitClk(2 * BIT);
    checkWord(1, "odd par bit0", 8'h07, 1'b0, modelParityErr(8'h07, 1'b0, 1'b1));
    applyStimulus(1, 8'h07, 1'b1, 1'b1, 1'b1);
    waitClk(2 * BIT);
    checkWord(1, "odd par bit1", 8'h07, 1'b0, modelParityErr(8'h07, 1'b1, 1'b1));

    // Randomised frames on both instances against the reference rules
    readyA = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      rp = 1'($urandom_range(0, 1));
      fork
        applyStimulus(0, rd, 1'b0, 1'b0, rs);
        applyStimulus(1, rd, 1'b1, rp, rs);
      join
      waitClk(2 * BIT);
      if (gotB.size() == 1) begin
        word_t wb;
        wb = gotB.pop_front();
        checkOutput($sformatf("rand%0d B data", k), wb.data, rd);
        checkOutput($sformatf("rand%0d B frame_err", k), wb.ferr, !rs);
        checkOutput($sformatf("rand%0d B parity_err", k), wb.perr, modelParityErr(rd, rp, 1'b1));
      end else begin
        checkOutput($sformatf("rand%0d B word count", k), gotB.size(), 1);
      end
      checkWord(0, $sformatf("rand%0d A", k), rd, !rs, 1'b0);
    end

    // Reset mid data bit 4 with a held word and overrun pending
    readyA = 1'b0;
    applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b1);
    waitClk(BIT);
    applyStimulus(0, 8'h66, 1'b0, 1'b0, 1'b1);
    waitClk(2 * BIT);
    setLine(0, 1'b0);
    waitClk(BIT);
    for (int i = 0; i < 4; i++) begin
      setLine(0, rd[i]);
      waitClk(BIT);
    end
    setLine(0, 1'b1);
    waitClk(BIT / 2);
    checkOutput("pre-reset busy", busyA, 1);
    checkOutput("pre-reset valid", validA, 1);
    checkOutput("pre-reset overrun", ovrA, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("async reset valid", validA, 0);
    checkOutput("async reset data", dataA, 0);
    checkOutput("async reset frame_err", ferrA, 0);
    checkOutput("async reset overrun", ovrA, 0);
    checkOutput("async reset busy", busyA, 0);
    waitClk(4);
    reset_n = 1'b1;
    waitClk(BIT);
    gotA.delete();
    readyA = 1'b1;
    applyStimulus(0, 8'hC3, 1'b0, 1'b0, 1'b1);
    waitClk(2 * BIT);
    checkWord(0, "after reset", 8'hC3, 1'b0, 1'b0);
    checkOutput("after reset overrun", ovrA, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
